exec_md_unit: RTL and testbench
===============================

Name: exec_md_unit

Overview:
- Parametrised next-generation execute stage for the single-issue MIPS core.
- Keeps the combinational ALU, shifter and branch-target datapath, generalised to XLEN bits.
- Adds a sequential multiply/divide unit with HI/LO registers: iterative radix-2 mult/multu/div/divu plus mfhi/mflo/mthi/mtlo.
- A Stall handshake back to the fetch/decode control holds dependent instructions until HI/LO are valid.

Parameters:
- XLEN, 32: datapath width; must be even and at least 8.
- SHW, $clog2(XLEN): shift-amount width (derived).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- Exe_valid  in  1  a valid instruction is presented this cycle
- Read_data_1  in  XLEN  rs operand
- Read_data_2  in  XLEN  rt operand
- Sign_extend  in  XLEN  extended immediate
- PC_plus_4  in  XLEN  PC+4 from fetch
- Function_opcode  in  6  instruction[5:0]
- Exe_opcode  in  6  instruction[31:26]
- Shamt  in  SHW  shift amount field
- ALUOp  in  2  controller ALU class
- ALUSrc, I_format, Sftmd  in  1 each  controller flags, same meaning as the current execute stage
- ALU_Result  out  XLEN  data result (combinational)
- Zero  out  1  ALU mux result equals 0
- Addr_Result  out  XLEN  PC_plus_4 + (Sign_extend << 2), modulo 2^XLEN
- Stall  out  1  hold the current instruction; do not advance the PC
- Div_zero  out  1  one-cycle pulse when a divide by zero completes
- Md_busy  out  1  multiply/divide iteration in progress

Behaviour:
- ALU, shifts, slt family and lui:
  - Identical decode to the 32-bit execute stage, widened to XLEN.
  - lui result = {Binput[XLEN/2-1:0], XLEN/2 zeros}.
  - Variable shifts use Read_data_1[SHW-1:0] only.
- MD decode: an MD op is ALUOp==2'b10, I_format==0 and funct in:
  - 011000 mult, 011001 multu, 011010 div, 011011 divu
  - 010000 mfhi, 010010 mflo, 010001 mthi, 010011 mtlo
- The MD FSM only acts when Exe_valid=1 and Stall=0.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE, on mult/multu: latch operands as magnitudes for signed ops and record the result sign; cnt<=XLEN; go to MUL.
  - IDLE, on div/divu: latch the same way, recording quotient and remainder signs; cnt<=XLEN; go to DIV.
  - MUL: shift-add one bit per cycle on a 2*XLEN accumulator; cnt--; go to DONE when cnt reaches 1.
  - DIV: restoring division, one quotient bit per cycle; go to DONE the same way.
  - DONE (one cycle): apply sign fix-up, then write HI/LO.
    - Multiply: HI = upper half, LO = lower half.
    - Divide: LO = quotient, HI = remainder; remainder takes the dividend's sign.
    - Return to IDLE.
  - mthi/mtlo in IDLE: write HI or LO with Read_data_1 at the clock edge; state unchanged.
- Latency:
  - The issue edge enters MUL/DIV; XLEN cycles in MUL/DIV, then DONE.
  - HI/LO are updated at the end of the DONE cycle, XLEN+1 cycles after the issue edge.
- Md_busy = (state != IDLE).
- Stall = Exe_valid & MD op & Md_busy. Mult/div itself is fire-and-forget; non-MD instructions never stall.
- mfhi/mflo:
  - ALU_Result = HI or LO, combinational, and only when not stalled.
  - While stalled, ALU_Result = 0, so a write-back in that cycle is harmless.
- Divide by zero:
  - LO = all ones, HI = dividend, for both signed and unsigned divides.
  - Div_zero = 1 during the DONE cycle only.
- Signed overflow (MIN / -1): LO = MIN, HI = 0, with no flag.
- Reset, including mid-operation: state = IDLE, cnt = 0, HI = LO = 0, Md_busy = Stall = Div_zero = 0. Any in-flight result is discarded.
- Combinational outputs follow their inputs immediately after reset.

Test Plan:
- mult -5 by 3 (XLEN=32) -> Md_busy for 33 cycles, then HI=FFFFFFFF, LO=FFFFFFF1; mflo issued afterwards returns FFFFFFF1 with no Stall.
- divu 100 by 7 -> LO=0000000E, HI=00000002. Then div -7 by 2 -> LO=FFFFFFFD, HI=FFFFFFFF.
- mflo issued 1 cycle after div -> Stall=1 until DONE completes; the first non-stalled cycle returns the new LO; PC hold verified.
- div 5 by 0 -> Div_zero pulses exactly 1 cycle, LO=FFFFFFFF, HI=00000005. Then div 80000000 by FFFFFFFF -> LO=80000000, HI=0.
- Reset asserted in cycle 10 of a divide -> next cycle Md_busy=0, HI=LO=0; a following mfhi returns 0.
- XLEN=16 build: multu FFFF by FFFF -> HI=FFFE, LO=0001 after 17 cycles. sllv by 0x13 -> shift by 3. add/slt/lui regression matches the 32-bit build, truncated to 16 bits.

Source files
------------

// File: rtl/exec_md_unit.sv
`default_nettype none
// ============================================================================
// exec_md_unit : XLEN-bit MIPS execute stage with iterative mul/div and HI/LO
// Rev 1.0
// ============================================================================
module exec_md_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            Exe_valid,
    input  logic [XLEN-1:0] Read_data_1,
    input  logic [XLEN-1:0] Read_data_2,
    input  logic [XLEN-1:0] Sign_extend,
    input  logic [XLEN-1:0] PC_plus_4,
    input  logic [5:0]      Function_opcode,
    input  logic [5:0]      Exe_opcode,
    input  logic [SHW-1:0]  Shamt,
    input  logic [1:0]      ALUOp,
    input  logic            ALUSrc,
    input  logic            I_format,
    input  logic            Sftmd,
    output logic [XLEN-1:0] ALU_Result,
    output logic            Zero,
    output logic [XLEN-1:0] Addr_Result,
    output logic            Stall,
    output logic            Div_zero,
    output logic            Md_busy
);
    localparam int c_CNT_W = SHW + 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} md_state_t;
    md_state_t r_state, w_state_nxt;

    logic [XLEN-1:0]    w_bin, w_alu_mux, w_shift, w_mag_a, w_mag_b, w_quo, w_rem;
    logic [5:0]         w_exe_code;
    logic [2:0]         w_alu_ctl;
    logic               w_is_slt, w_lt, w_is_lui, w_unused;
    logic               w_r_md, w_is_mul, w_is_div, w_is_mfhi, w_is_mflo, w_is_mthi, w_is_mtlo;
    logic               w_md_op, w_fire, w_signed, w_a_neg, w_b_neg, w_div_ge;
    logic [XLEN:0]      w_mul_sum, w_div_top, w_div_diff;
    logic [2*XLEN-1:0]  w_mul_nxt, w_div_nxt, w_prod_fix;

    logic [XLEN-1:0]    r_hi, r_lo, r_opb;
    logic [2*XLEN-1:0]  r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_is_div, r_qsgn, r_rsgn, r_dz;

    assign w_unused = ^Exe_opcode[5:3];

    // ALU control decode inherited from the 32-bit execute stage
    assign w_bin         = ALUSrc ? Sign_extend : Read_data_2;
    assign w_exe_code    = I_format ? {3'b000, Exe_opcode[2:0]} : Function_opcode;
    assign w_alu_ctl[0]  = (w_exe_code[0] | w_exe_code[3]) & ALUOp[1];
    assign w_alu_ctl[1]  = ~w_exe_code[2] | ~ALUOp[1];
    assign w_alu_ctl[2]  = (w_exe_code[1] & ALUOp[1]) | ALUOp[0];

    always_comb begin
        w_alu_mux = '0;
        case (w_alu_ctl)
            3'b000:         w_alu_mux = Read_data_1 & w_bin;
            3'b001:         w_alu_mux = Read_data_1 | w_bin;
            3'b010, 3'b011: w_alu_mux = Read_data_1 + w_bin;
            3'b100:         w_alu_mux = Read_data_1 ^ w_bin;
            3'b101:         w_alu_mux = ~(Read_data_1 | w_bin);
            default:        w_alu_mux = Read_data_1 - w_bin;
        endcase
    end

    always_comb begin
        w_shift = w_bin;
        if (Sftmd) begin
            case (Function_opcode[2:0])
                3'b000:  w_shift = w_bin << Shamt;
                3'b010:  w_shift = w_bin >> Shamt;
                3'b011:  w_shift = $signed(w_bin) >>> Shamt;
                3'b100:  w_shift = w_bin << Read_data_1[SHW-1:0];
                3'b110:  w_shift = w_bin >> Read_data_1[SHW-1:0];
                3'b111:  w_shift = $signed(w_bin) >>> Read_data_1[SHW-1:0];
                default: w_shift = w_bin;
            endcase
        end
    end

    assign w_is_slt = ((w_alu_ctl == 3'b111) && w_exe_code[3]) || ((w_alu_ctl[2:1] == 2'b11) && I_format);
    assign w_lt     = w_exe_code[0] ? (Read_data_1 < w_bin) : ($signed(Read_data_1) < $signed(w_bin));
    assign w_is_lui = (w_alu_ctl == 3'b101) && I_format;

    // HI/LO moves
    assign w_r_md    = (ALUOp == 2'b10) && !I_format;
    assign w_is_mul  = w_r_md && (Function_opcode[5:1] == 5'b01100);
    assign w_is_div  = w_r_md && (Function_opcode[5:1] == 5'b01101);
    assign w_is_mfhi = w_r_md && (Function_opcode == 6'b010000);
    assign w_is_mthi = w_r_md && (Function_opcode == 6'b010001);
    assign w_is_mflo = w_r_md && (Function_opcode == 6'b010010);
    assign w_is_mtlo = w_r_md && (Function_opcode == 6'b010011);
    assign w_md_op   = w_is_mul | w_is_div | w_is_mfhi | w_is_mthi | w_is_mflo | w_is_mtlo;

    assign Md_busy  = (r_state != S_IDLE);
    assign Stall    = Exe_valid & w_md_op & Md_busy;
    assign w_fire   = Exe_valid & ~Stall;
    assign Div_zero = (r_state == S_DONE) & r_is_div & r_dz;

    always_comb begin
        if (w_is_mfhi)      ALU_Result = Stall ? '0 : r_hi;
        else if (w_is_mflo) ALU_Result = Stall ? '0 : r_lo;
        else if (w_is_slt)  ALU_Result = {{(XLEN-1){1'b0}}, w_lt};
        else if (w_is_lui)  ALU_Result = {w_bin[XLEN/2-1:0], {(XLEN/2){1'b0}}};
        else if (Sftmd)     ALU_Result = w_shift;
        else                ALU_Result = w_alu_mux;
    end

    assign Zero        = (w_alu_mux == '0);
    assign Addr_Result = PC_plus_4 + (Sign_extend << 2);

    // Signed ops run on magnitudes; signs are reapplied in DONE
    assign w_signed = ~Function_opcode[0];
    assign w_a_neg  = w_signed & Read_data_1[XLEN-1];
    assign w_b_neg  = w_signed & Read_data_2[XLEN-1];
    assign w_mag_a  = w_a_neg ? -Read_data_1 : Read_data_1;
    assign w_mag_b  = w_b_neg ? -Read_data_2 : Read_data_2;

    // Accumulator: multiply = {partial product, multiplier}; divide = {remainder, quotient}
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
    assign w_mul_nxt  = {w_mul_sum, r_acc[XLEN-1:1]};
    assign w_div_top  = r_acc[2*XLEN-1:XLEN-1];
    assign w_div_ge   = (w_div_top >= {1'b0, r_opb});
    assign w_div_diff = w_div_top - {1'b0, r_opb};
    assign w_div_nxt  = w_div_ge ? {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1}
                                 : {w_div_top[XLEN-1:0],  r_acc[XLEN-2:0], 1'b0};
    assign w_prod_fix = r_qsgn ? -r_acc : r_acc;
    assign w_quo      = r_acc[XLEN-1:0];
    assign w_rem      = r_acc[2*XLEN-1:XLEN];

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fire && w_is_mul)      w_state_nxt = S_MUL;
                else if (w_fire && w_is_div) w_state_nxt = S_DIV;
            end
            S_MUL, S_DIV: if (r_cnt == c_CNT_W'(1)) w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_qsgn   <= 1'b0;
            r_rsgn   <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fire && (w_is_mul || w_is_div)) begin
                        r_acc    <= {{XLEN{1'b0}}, w_mag_a};
                        r_opb    <= w_mag_b;
                        r_cnt    <= c_CNT_W'(XLEN);
                        r_is_div <= w_is_div;
                        r_qsgn   <= w_a_neg ^ w_b_neg;
                        r_rsgn   <= w_a_neg;
                        r_dz     <= (Read_data_2 == '0);
                    end else if (w_fire && w_is_mthi) begin
                        r_hi <= Read_data_1;
                    end else if (w_fire && w_is_mtlo) begin
                        r_lo <= Read_data_1;
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_nxt;
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end
                S_DIV: begin
                    r_acc <= w_div_nxt;
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end
                default: begin
                    if (r_is_div) begin
                        r_lo <= r_dz ? '1 : (r_qsgn ? -w_quo : w_quo);
                        r_hi <= r_rsgn ? -w_rem : w_rem;
                    end else begin
                        r_hi <= w_prod_fix[2*XLEN-1:XLEN];
                        r_lo <= w_prod_fix[XLEN-1:0];
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exec_md_unit.sv
`default_nettype none
// ============================================================================
// tb_exec_md_unit : randomized self-checking bench for exec_md_unit
// Rev 1.0
// ============================================================================
module tb_exec_md_unit;
    localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010, F_DIVU = 6'b011011;
    localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001, F_MFLO = 6'b010010, F_MTLO = 6'b010011;
    localparam logic [5:0] R_OPS [16] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                                          6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
                                          6'b000011, 6'b000100, 6'b000110, 6'b000111};
    localparam logic [5:0] I_OPS [8]  = '{6'b001000, 6'b001001, 6'b001010, 6'b001011,
                                          6'b001100, 6'b001101, 6'b001110, 6'b001111};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ev, alusrc, ifmt, sftmd;
    logic [31:0] rd1, rd2, sext, pc4;
    logic [5:0]  fn, op;
    logic [4:0]  shamt;
    logic [1:0]  aluop;
    logic [31:0] alu_res, addr_res;
    logic        zero, stall, dz, busy;

    exec_md_unit #(.XLEN(32)) dut (
        .clock(clk), .reset(rst), .Exe_valid(ev), .Read_data_1(rd1), .Read_data_2(rd2),
        .Sign_extend(sext), .PC_plus_4(pc4), .Function_opcode(fn), .Exe_opcode(op),
        .Shamt(shamt), .ALUOp(aluop), .ALUSrc(alusrc), .I_format(ifmt), .Sftmd(sftmd),
        .ALU_Result(alu_res), .Zero(zero), .Addr_Result(addr_res), .Stall(stall),
        .Div_zero(dz), .Md_busy(busy)
    );

    logic        ev16, src16, if16, sft16;
    logic [15:0] a16, b16, se16, pc16, res16, addr16;
    logic [5:0]  fn16, op16;
    logic [3:0]  sh16;
    logic [1:0]  aluop16;
    logic        zero16, stall16, dz16, busy16;

    exec_md_unit #(.XLEN(16)) dut16 (
        .clock(clk), .reset(rst), .Exe_valid(ev16), .Read_data_1(a16), .Read_data_2(b16),
        .Sign_extend(se16), .PC_plus_4(pc16), .Function_opcode(fn16), .Exe_opcode(op16),
        .Shamt(sh16), .ALUOp(aluop16), .ALUSrc(src16), .I_format(if16), .Sftmd(sft16),
        .ALU_Result(res16), .Zero(zero16), .Addr_Result(addr16), .Stall(stall16),
        .Div_zero(dz16), .Md_busy(busy16)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Architectural reference: HI/LO after an MD instruction
    function automatic void md_ref(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
        longint      sa = $signed(a);
        longint      sb = $signed(b);
        logic [63:0] p;
        longint      q, r;
        hi = '0; lo = '0;
        case (f)
            F_MULT:  begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            F_MULTU: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
            F_DIV: begin
                if (b == 0) begin lo = '1; hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = '0; end
                else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
            end
            default: begin
                if (b == 0) begin lo = '1; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endfunction

    function automatic logic [31:0] alu_ref(input logic is_i, input logic [5:0] c, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sa);
        logic [4:0] va = a[4:0];
        if (!is_i) begin
            case (c)
                6'b100000, 6'b100001: return a + b;
                6'b100010, 6'b100011: return a - b;
                6'b100100: return a & b;
                6'b100101: return a | b;
                6'b100110: return a ^ b;
                6'b100111: return ~(a | b);
                6'b101010: return {31'b0, $signed(a) < $signed(b)};
                6'b101011: return {31'b0, a < b};
                6'b000000: return b << sa;
                6'b000010: return b >> sa;
                6'b000011: return $signed(b) >>> sa;
                6'b000100: return b << va;
                6'b000110: return b >> va;
                default:   return $signed(b) >>> va;
            endcase
        end
        case (c)
            6'b001010: return {31'b0, $signed(a) < $signed(b)};
            6'b001011: return {31'b0, a < b};
            6'b001100: return a & b;
            6'b001101: return a | b;
            6'b001110: return a ^ b;
            6'b001111: return {b[15:0], 16'h0000};
            default:   return a + b;
        endcase
    endfunction

    task automatic idle();
        ev = 1'b0; aluop = 2'b00; ifmt = 1'b0; alusrc = 1'b0; sftmd = 1'b0;
        fn = 6'd0; op = 6'd0; rd1 = '0; rd2 = '0; sext = '0; pc4 = '0; shamt = '0;
    endtask

    task automatic drive_r(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        ev = 1'b1; aluop = 2'b10; ifmt = 1'b0; alusrc = 1'b0; sftmd = 1'b0;
        fn = f; op = 6'd0; rd1 = a; rd2 = b;
    endtask

    // Leaves the caller at the falling edge right after the issue edge
    task automatic md_issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk); drive_r(f, a, b);
        @(negedge clk); idle();
    endtask

    task automatic wait_done(output int busy_cyc, output int dz_cyc);
        busy_cyc = 0; dz_cyc = 0;
        for (int i = 0; i < 200 && busy; i++) begin
            busy_cyc++;
            if (dz) dz_cyc++;
            @(negedge clk);
        end
        if (busy) chk("md_timeout", 32'(busy), 32'd0);
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo, output logic st);
        @(negedge clk); drive_r(F_MFHI, $urandom, $urandom); #1; hi = alu_res; st = stall;
        @(negedge clk); drive_r(F_MFLO, $urandom, $urandom); #1; lo = alu_res; st = st | stall;
        @(negedge clk); idle();
    endtask

    task automatic md_check(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el, gh, gl;
        logic        st;
        int          bc, dc;
        md_ref(f, a, b, eh, el);
        md_issue(f, a, b);
        wait_done(bc, dc);
        read_hilo(gh, gl, st);
        chk({tag, "_hi"}, gh, eh);
        chk({tag, "_lo"}, gl, el);
    endtask

    initial begin
        logic [31:0] gh, gl, eh, el;
        logic        st;
        int          bc, dc, sc, zbad;

        rst = 1'b1; idle();
        ev16 = 1'b0; src16 = 1'b0; if16 = 1'b0; sft16 = 1'b0; a16 = '0; b16 = '0;
        se16 = '0; pc16 = '0; fn16 = '0; op16 = '0; sh16 = '0; aluop16 = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_divzero", 32'(dz), 32'd0);
        read_hilo(gh, gl, st);
        chk("rst_hi", gh, 32'd0);
        chk("rst_lo", gl, 32'd0);
        chk("rst_stall", 32'(st), 32'd0);

        // mult -5 * 3: busy window, then reads without stall
        md_issue(F_MULT, 32'hFFFF_FFFB, 32'd3);
        wait_done(bc, dc);
        chk("mult_busy_cycles", 32'(bc), 32'd33);
        chk("mult_no_divzero", 32'(dc), 32'd0);
        read_hilo(gh, gl, st);
        chk("mult_hi", gh, 32'hFFFF_FFFF);
        chk("mult_lo", gl, 32'hFFFF_FFF1);
        chk("mf_stall", 32'(st), 32'd0);

        md_check("divu_100_7", F_DIVU, 32'd100, 32'd7);
        md_check("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'd2);

        md_issue(F_DIV, 32'd5, 32'd0);
        wait_done(bc, dc);
        chk("div0_pulse", 32'(dc), 32'd1);
        read_hilo(gh, gl, st);
        chk("div0_hi", gh, 32'd5);
        chk("div0_lo", gl, 32'hFFFF_FFFF);
        md_check("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);

        // Non-MD instruction during a multiply must not stall
        md_issue(F_MULTU, 32'd9, 32'd9);
        drive_r(6'b100000, 32'd40, 32'd2); #1;
        chk("busy_add_stall", 32'(stall), 32'd0);
        chk("busy_add_res", alu_res, 32'd42);
        @(negedge clk); idle();
        wait_done(bc, dc);

        // mflo right behind a divide: held until DONE retires
        md_issue(F_DIV, 32'd1000, 32'd7);
        drive_r(F_MFLO, 32'd0, 32'd0);
        sc = 0; zbad = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!stall) break;
            sc++;
            if (alu_res != 0) zbad++;
            @(negedge clk);
        end
        chk("stall_cycles", 32'(sc), 32'd33);
        chk("stall_result_zero", 32'(zbad), 32'd0);
        chk("stall_first_lo", alu_res, 32'd142);
        @(negedge clk); idle();

        // Reset in cycle 10 of a divide
        md_issue(F_DIVU, 32'hDEAD_BEEF, 32'd3);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        read_hilo(gh, gl, st);
        chk("midrst_hi", gh, 32'd0);
        chk("midrst_lo", gl, 32'd0);

        // Random multiply/divide and HI/LO moves
        for (int i = 0; i < 16; i++) begin
            logic [5:0]  f;
            logic [31:0] a, b;
            f = 6'b011000 | 6'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 255);
                default: b = $urandom;
            endcase
            if (i == 5) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; f = F_DIV; end
            md_check("rand_md", f, a, b);
            eh = $urandom; el = $urandom;
            @(negedge clk); drive_r(F_MTHI, eh, $urandom);
            @(negedge clk); drive_r(F_MTLO, el, $urandom);
            @(negedge clk); idle();
            read_hilo(gh, gl, st);
            chk("mthi", gh, eh);
            chk("mtlo", gl, el);
        end

        // Random ALU / shift / immediate operations and branch target
        for (int i = 0; i < 48; i++) begin
            logic [31:0] a, b, pc;
            logic [4:0]  s;
            logic [5:0]  c;
            logic        isi;
            a = $urandom; b = $urandom; pc = $urandom; s = 5'($urandom_range(0, 31));
            isi = ($urandom_range(0, 2) == 0);
            if (i % 6 == 0) b = a;
            @(negedge clk);
            if (isi) begin
                c = I_OPS[$urandom_range(0, 7)];
                ev = 1'b1; aluop = 2'b10; ifmt = 1'b1; alusrc = 1'b1; sftmd = 1'b0;
                op = c; fn = b[5:0]; rd1 = a; rd2 = $urandom; sext = b;
            end else begin
                c = R_OPS[$urandom_range(0, 15)];
                if (i % 6 == 0) c = 6'b100010;
                ev = 1'b1; aluop = 2'b10; ifmt = 1'b0; alusrc = 1'b0; sftmd = (c[5:3] == 3'b000);
                op = 6'd0; fn = c; rd1 = a; rd2 = b; sext = $urandom;
            end
            shamt = s; pc4 = pc;
            #1;
            chk("alu", alu_res, alu_ref(isi, c, a, b, s));
            chk("addr", addr_res, pc + {sext[29:0], 2'b00});
            if (!isi && c == 6'b100010) chk("zero", 32'(zero), 32'(a == b));
        end
        @(negedge clk); idle();

        // 16-bit build
        @(negedge clk);
        ev16 = 1'b1; aluop16 = 2'b10; if16 = 1'b0; src16 = 1'b0; sft16 = 1'b0;
        fn16 = F_MULTU; a16 = 16'hFFFF; b16 = 16'hFFFF;
        @(negedge clk);
        ev16 = 1'b0;
        bc = 0;
        for (int i = 0; i < 100 && busy16; i++) begin bc++; @(negedge clk); end
        chk("x16_busy_cycles", 32'(bc), 32'd17);
        ev16 = 1'b1; fn16 = F_MFHI; #1;
        chk("x16_hi", 32'(res16), 32'h0000_FFFE);
        fn16 = F_MFLO; #1;
        chk("x16_lo", 32'(res16), 32'h0000_0001);
        @(negedge clk);
        fn16 = 6'b000100; sft16 = 1'b1; a16 = 16'h0013; b16 = 16'h0001; #1;
        chk("x16_sllv", 32'(res16), 32'h0000_0008);
        fn16 = 6'b100000; sft16 = 1'b0; a16 = 16'h1234; b16 = 16'h0FFF; #1;
        chk("x16_add", 32'(res16), 32'h0000_2233);
        fn16 = 6'b101010; a16 = 16'h8000; b16 = 16'h0001; #1;
        chk("x16_slt", 32'(res16), 32'h0000_0001);
        if16 = 1'b1; src16 = 1'b1; op16 = 6'b001111; se16 = 16'h1234; #1;
        chk("x16_lui", 32'(res16), 32'h0000_3400);
        @(negedge clk);
        ev16 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
